// File: rtl/ksl_add_scheduler.sv
`timescale 1ns/1ps
// ksl_add_scheduler
//
// Purpose
//   Time-shares one fixed-latency KSL-attenuation ROM across all OPL3
//   operators. The register-write decoder posts fnum/block/ksl updates per
//   operator. Only operators marked dirty by an update are recomputed. Results
//   land in a per-operator ksl_add table that the envelope pipeline reads.
//
// Ports
//   clk          rising-edge clock for every flop
//   reset_n      asynchronous, active-low reset
//   upd_valid    update strobe. It is always accepted.
//   upd_op       operator index of the update. Indices >= NUM_OPS are ignored.
//   upd_fnum     new fnum for upd_op
//   upd_block    new block for upd_op
//   upd_ksl      new ksl for upd_op
//   rom_fnum     registered ROM operand
//   rom_block    registered ROM operand
//   rom_ksl      registered ROM operand
//   rom_ksl_add  ROM result. It is sampled ROM_LATENCY edges after the operands launch.
//   rd_op        table read index
//   rd_ksl_add   table[rd_op], registered, read-before-write
//   busy         high in INIT, or while any dirty op or foreground tag is in flight
//
// Configuration
//   KSL_SCHED_REFRESH_EN  When it is defined, idle issue slots run a background
//                         round-robin recompute of every operator.
//                         busy does not count this background traffic.

package opl3_pkg;
  localparam int REG_FNUM_WIDTH  = 10;
  localparam int REG_BLOCK_WIDTH = 3;
  localparam int REG_KSL_WIDTH   = 2;
  localparam int KSL_ADD_WIDTH   = 8;
endpackage

module ksl_add_scheduler
  import opl3_pkg::*;
#(
  parameter int NUM_OPS     = 36,
  parameter int ROM_LATENCY = 2,
  localparam int OP_W       = $clog2(NUM_OPS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       upd_valid,
  input  logic [OP_W-1:0]            upd_op,
  input  logic [REG_FNUM_WIDTH-1:0]  upd_fnum,
  input  logic [REG_BLOCK_WIDTH-1:0] upd_block,
  input  logic [REG_KSL_WIDTH-1:0]   upd_ksl,
  output logic [REG_FNUM_WIDTH-1:0]  rom_fnum,
  output logic [REG_BLOCK_WIDTH-1:0] rom_block,
  output logic [REG_KSL_WIDTH-1:0]   rom_ksl,
  input  logic [KSL_ADD_WIDTH-1:0]   rom_ksl_add,
  input  logic [OP_W-1:0]            rd_op,
  output logic [KSL_ADD_WIDTH-1:0]   rd_ksl_add,
  output logic                       busy
);

  localparam int SUM_W = OP_W + 1;
  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_t;

  state_t state_q, state_d;
  logic [OP_W-1:0] init_idx_q;

  logic [REG_FNUM_WIDTH-1:0]  fnum_q  [NUM_OPS];
  logic [REG_BLOCK_WIDTH-1:0] block_q [NUM_OPS];
  logic [REG_KSL_WIDTH-1:0]   ksl_q   [NUM_OPS];
  logic [NUM_OPS-1:0]         dirty_q, dirty_d;
  logic [OP_W-1:0]            last_q;

  logic [ROM_LATENCY-1:0] tag_vld_q;
  logic [ROM_LATENCY-1:0] tag_fg_q;
  logic [OP_W-1:0]        tag_op_q [ROM_LATENCY];

  logic [KSL_ADD_WIDTH-1:0] ksl_table [NUM_OPS];

  logic [OP_W-1:0]  start;
  logic [SUM_W-1:0] sum;
  logic [OP_W-1:0]  cand;
  logic [OP_W-1:0]  pick;
  logic             found;
  logic             upd_hit;
  logic             issue_valid;
  logic             issue_fg;
  logic [OP_W-1:0]  issue_op;
  logic             wb_valid;
  logic [OP_W-1:0]  wb_op;

  assign upd_hit = upd_valid && (upd_op <= LAST_OP);
  assign start   = (last_q == LAST_OP) ? '0 : last_q + 1'b1;

  // Round-robin search for the first dirty op, starting one past the last
  // issued op. The sum is one bit wider so the modulo wrap cannot overflow.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      sum = {1'b0, start} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_OPS)) sum = sum - SUM_W'(NUM_OPS);
      cand = sum[OP_W-1:0];
      if (!found && dirty_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Issue happens in the same cycle that a dirty bit is seen, in IDLE or RUN.
  // This gives an update-to-writeback latency of ROM_LATENCY + 1 edges.
`ifdef KSL_SCHED_REFRESH_EN
  assign issue_valid = (state_q != ST_INIT);
`else
  assign issue_valid = (state_q != ST_INIT) && found;
`endif
  assign issue_fg = found;
  assign issue_op = found ? pick : start;

  // The set from an update wins over the clear from an issue.
  // An op updated while it issues therefore goes out again with the new parameters.
  always_comb begin
    dirty_d = dirty_q;
    if (issue_valid && issue_fg) dirty_d[issue_op] = 1'b0;
    if (upd_hit) dirty_d[upd_op] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_idx_q == LAST_OP) state_d = ST_IDLE;
      ST_IDLE: if (|dirty_q) state_d = ST_RUN;
      ST_RUN:  if (!(|dirty_q)) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT)
        init_idx_q <= (init_idx_q == LAST_OP) ? '0 : init_idx_q + 1'b1;
    end
  end

  // Parameter store, dirty bits, RR pointer and ROM operand registers.
  // While nothing issues, the ROM operands hold their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        fnum_q[i]  <= '0;
        block_q[i] <= '0;
        ksl_q[i]   <= '0;
      end
      dirty_q   <= '0;
      last_q    <= '0;
      rom_fnum  <= '0;
      rom_block <= '0;
      rom_ksl   <= '0;
    end else begin
      dirty_q <= dirty_d;
      if (upd_hit) begin
        fnum_q[upd_op]  <= upd_fnum;
        block_q[upd_op] <= upd_block;
        ksl_q[upd_op]   <= upd_ksl;
      end
      if (issue_valid) begin
        rom_fnum  <= fnum_q[issue_op];
        rom_block <= block_q[issue_op];
        rom_ksl   <= ksl_q[issue_op];
        last_q    <= issue_op;
      end
    end
  end

  // Tag pipe that tracks the ROM latency.
  // Reset empties it, so results that are in flight during a reset are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      tag_fg_q  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) tag_op_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= issue_valid;
      tag_fg_q[0]  <= issue_valid && issue_fg;
      tag_op_q[0]  <= issue_op;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_fg_q[i]  <= tag_fg_q[i-1];
        tag_op_q[i]  <= tag_op_q[i-1];
      end
    end
  end

  assign wb_valid = tag_vld_q[ROM_LATENCY-1];
  assign wb_op    = tag_op_q[ROM_LATENCY-1];

  // Table storage has no reset. INIT clears it one entry per cycle.
  // No tag can be in flight during INIT, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)
      ksl_table[init_idx_q] <= '0;
    else if (wb_valid)
      ksl_table[wb_op] <= rom_ksl_add;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_ksl_add <= '0;
    else
      rd_ksl_add <= (rd_op <= LAST_OP) ? ksl_table[rd_op] : '0;
  end

  assign busy = (state_q == ST_INIT) || (|dirty_q) || (|(tag_vld_q & tag_fg_q));

endmodule
